// File: rtl/rv_mem_lsu_pkg.sv
// rv_mem_lsu_pkg
//   Shared definitions for the MEM-stage load/store unit.
//   - funct3 access-size codes (B, H, W, BU, HU)
//   - FSM state encoding (3-bit)
//   - access-size decode and load-sign helpers
package rv_mem_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ0 = 3'd1,
        ST_RSP0 = 3'd2,
        ST_REQ1 = 3'd3,
        ST_RSP1 = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Unused codes (011, 110, 111) fall through to a zero-extended word.
    function automatic lsu_size_e decode_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            LSU_B, LSU_BU: sz = SZ_B;
            LSU_H, LSU_HU: sz = SZ_H;
            LSU_W:         sz = SZ_W;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_signed_load(input logic [2:0] f3);
        return (f3 == LSU_B) || (f3 == LSU_H);
    endfunction

endpackage

// File: rtl/rv_mem_lsu_align.sv
// rv_mem_lsu_align
//   Combinational byte-lane alignment for the load/store unit.
//   Ports:
//     bytectrl  in  3   funct3 access code
//     off       in  2   byte offset within the word (addr[1:0])
//     wd        in  32  store data, right-justified
//     lo        in  32  read word of beat 0
//     hi        in  32  read word of beat 1 (don't care when not split)
//     mask8     out 8   byte enables over two words; [3:0] beat 0, [7:4] beat 1
//     wide      out 64  store data shifted to its lanes over two words
//     load_data out 32  extracted and extended load result
//     split     out 1   access crosses a word boundary
module rv_mem_lsu_align
    import rv_mem_lsu_pkg::*;
(
    input  logic [2:0]  bytectrl,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  mask8,
    output logic [63:0] wide,
    output logic [31:0] load_data,
    output logic        split
);

    lsu_size_e   size;
    logic        sext;
    logic [3:0]  base_mask;
    logic [31:0] shifted;

    always_comb begin
        size = decode_size(bytectrl);
        sext = is_signed_load(bytectrl);

        case (size)
            SZ_B:    base_mask = 4'b0001;
            SZ_H:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase

        mask8 = {4'b0000, base_mask} << off;
        wide  = {32'b0, wd} << {off, 3'b000};

        // Only the low 32 bits after the shift can hold the addressed bytes.
        shifted = 32'({hi, lo} >> {off, 3'b000});

        case (size)
            SZ_B:    load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase

        split = ((size == SZ_W) && (off != 2'd0)) ||
                ((size == SZ_H) && (off == 2'd3));
    end

endmodule

// File: rtl/rv_mem_lsu.sv
// rv_mem_lsu
//   MEM-stage load/store unit. Takes the EX/MEM request, drives a
//   valid/ready word bus (one or two beats), extends load data and stalls
//   the pipeline until the access completes.
//   Ports:
//     i_lsu_clk, i_lsu_rst        clock, asynchronous active-high reset
//     i_lsu_we / i_lsu_is_load    store / load request (store wins if both)
//     i_lsu_addr, i_lsu_wd        byte address, store data
//     i_lsu_bytectrl              funct3 access code
//     o_lsu_stall                 hold IF/ID/EX and EX/MEM
//     o_lsu_rd_valid/_rd_data     one-cycle load completion, extended result
//     o_lsu_bus_*                 request: valid, addr, we, wstrb, wdata
//     i_lsu_bus_ready             request accepted
//     i_lsu_bus_rvalid/_rdata     read response
//   Only XLEN = 32 is supported.
module rv_mem_lsu
    import rv_mem_lsu_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic            i_lsu_clk,
    input  logic            i_lsu_rst,
    input  logic            i_lsu_we,
    input  logic            i_lsu_is_load,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic [XLEN-1:0] i_lsu_wd,
    input  logic [2:0]      i_lsu_bytectrl,
    output logic            o_lsu_stall,
    output logic            o_lsu_rd_valid,
    output logic [XLEN-1:0] o_lsu_rd_data,
    output logic            o_lsu_bus_valid,
    input  logic            i_lsu_bus_ready,
    output logic [XLEN-1:0] o_lsu_bus_addr,
    output logic            o_lsu_bus_we,
    output logic [3:0]      o_lsu_bus_wstrb,
    output logic [XLEN-1:0] o_lsu_bus_wdata,
    input  logic            i_lsu_bus_rvalid,
    input  logic [XLEN-1:0] i_lsu_bus_rdata
);

    lsu_state_e  state_reg;
    logic [31:0] addr_reg;
    logic [31:0] wd_reg;
    logic [2:0]  f3_reg;
    logic        we_reg;
    logic [31:0] lo_reg;
    logic [31:0] rd_data_reg;

    logic        request;
    logic        bus_valid;
    logic        beat1;
    logic [31:0] base_addr;
    logic [31:0] lo_word;
    logic [7:0]  mask8;
    logic [63:0] wide;
    logic [31:0] load_data;
    logic        split;

    assign request = i_lsu_we | i_lsu_is_load;

    // In RSP0 the low word is still on the bus; afterwards it lives in lo_reg.
    assign lo_word = (state_reg == ST_RSP0) ? i_lsu_bus_rdata : lo_reg;

    rv_mem_lsu_align u_align (
        .bytectrl  (f3_reg),
        .off       (addr_reg[1:0]),
        .wd        (wd_reg),
        .lo        (lo_word),
        .hi        (i_lsu_bus_rdata),
        .mask8     (mask8),
        .wide      (wide),
        .load_data (load_data),
        .split     (split)
    );

    always_ff @(posedge i_lsu_clk or posedge i_lsu_rst) begin
        if (i_lsu_rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= 32'd0;
            wd_reg      <= 32'd0;
            f3_reg      <= 3'd0;
            we_reg      <= 1'b0;
            lo_reg      <= 32'd0;
            rd_data_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (request) begin
                        addr_reg  <= i_lsu_addr;
                        wd_reg    <= i_lsu_wd;
                        f3_reg    <= i_lsu_bytectrl;
                        we_reg    <= i_lsu_we;
                        state_reg <= ST_REQ0;
                    end
                end
                ST_REQ0: begin
                    if (i_lsu_bus_ready) begin
                        if (!we_reg)
                            state_reg <= ST_RSP0;
                        else if (split)
                            state_reg <= ST_REQ1;
                        else
                            state_reg <= ST_DONE;
                    end
                end
                ST_RSP0: begin
                    if (i_lsu_bus_rvalid) begin
                        lo_reg <= i_lsu_bus_rdata;
                        if (split) begin
                            state_reg <= ST_REQ1;
                        end else begin
                            rd_data_reg <= load_data;
                            state_reg   <= ST_DONE;
                        end
                    end
                end
                ST_REQ1: begin
                    if (i_lsu_bus_ready)
                        state_reg <= we_reg ? ST_DONE : ST_RSP1;
                end
                ST_RSP1: begin
                    if (i_lsu_bus_rvalid) begin
                        rd_data_reg <= load_data;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus_valid = (state_reg == ST_REQ0) || (state_reg == ST_REQ1);
    assign beat1     = (state_reg == ST_REQ1);
    assign base_addr = {addr_reg[31:2], 2'b00};

    assign o_lsu_bus_valid = bus_valid;
    assign o_lsu_bus_we    = bus_valid & we_reg;
    // Beat 1 address wraps naturally at 2^32.
    assign o_lsu_bus_addr  = bus_valid ? (beat1 ? base_addr + 32'd4 : base_addr) : 32'd0;
    assign o_lsu_bus_wstrb = (bus_valid & we_reg) ? (beat1 ? mask8[7:4] : mask8[3:0]) : 4'b0000;
    assign o_lsu_bus_wdata = (bus_valid & we_reg) ? (beat1 ? wide[63:32] : wide[31:0]) : 32'd0;

    // The IDLE term is combinational on the request, so it is masked by reset
    // to keep stall low for the whole reset window.
    assign o_lsu_stall = ~i_lsu_rst &
                         (((state_reg == ST_IDLE) & request) |
                          ((state_reg != ST_IDLE) && (state_reg != ST_DONE)));

    assign o_lsu_rd_valid = (state_reg == ST_DONE) & ~we_reg;
    assign o_lsu_rd_data  = rd_data_reg;

endmodule

// File: tb/tb_rv_mem_lsu.sv
module tb_rv_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, is_load;
    logic [31:0] addr, wd;
    logic [2:0]  bytectrl;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        stall, rd_valid, bus_valid, bus_we;
    logic [31:0] rd_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    always #5 clk = ~clk;

    rv_mem_lsu #(.XLEN(32)) dut (
        .i_lsu_clk        (clk),
        .i_lsu_rst        (rst),
        .i_lsu_we         (we),
        .i_lsu_is_load    (is_load),
        .i_lsu_addr       (addr),
        .i_lsu_wd         (wd),
        .i_lsu_bytectrl   (bytectrl),
        .o_lsu_stall      (stall),
        .o_lsu_rd_valid   (rd_valid),
        .o_lsu_rd_data    (rd_data),
        .o_lsu_bus_valid  (bus_valid),
        .i_lsu_bus_ready  (bus_ready),
        .o_lsu_bus_addr   (bus_addr),
        .o_lsu_bus_we     (bus_we),
        .o_lsu_bus_wstrb  (bus_wstrb),
        .o_lsu_bus_wdata  (bus_wdata),
        .i_lsu_bus_rvalid (bus_rvalid),
        .i_lsu_bus_rdata  (bus_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    logic [31:0] rd_words[$];
    logic [31:0] last_load = 32'd0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.we = w; b.strb = s; b.wdata = d;
        exp_beats.push_back(b);
    endtask

    // Drives one request, plays the bus slave and compares every accepted
    // beat and the completion against the scoreboard queues.
    task automatic access(input string name, input logic st, input logic ld,
                          input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          input int ready_wait, input int exp_stall);
        beat_t       e;
        int          stall_cnt = 0;
        int          beats_seen = 0;
        int          exp_n = exp_beats.size();
        bit          done = 0;
        bit          pend = 0;
        int          cyc = 0;
        logic [31:0] exp_data;
        we = st; is_load = ld; addr = a; wd = d; bytectrl = f3;
        bus_ready = (ready_wait == 0);
        while (!done && cyc < 60) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus_valid && bus_ready) begin
                beats_seen++;
                if (exp_beats.size() > 0) begin
                    e = exp_beats.pop_front();
                    check({name, ".addr"}, bus_addr, e.addr);
                    check({name, ".we"}, {31'd0, bus_we}, {31'd0, e.we});
                    check({name, ".wstrb"}, {28'd0, bus_wstrb}, {28'd0, e.strb});
                    if (e.we) check({name, ".wdata"}, bus_wdata, e.wdata);
                end
                if (!bus_we) pend = 1;
            end
            if (!stall) begin
                done = 1;
                check({name, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, ld & ~st});
                exp_data = (ld && !st && exp_rd.size() > 0) ? exp_rd.pop_front() : last_load;
                check({name, ".rd_data"}, rd_data, exp_data);
                last_load = exp_data;
            end
            @(posedge clk); #1;
            cyc++;
            bus_rvalid = 1'b0;
            if (pend) begin
                bus_rvalid = 1'b1;
                bus_rdata  = (rd_words.size() > 0) ? rd_words.pop_front() : 32'hBAD0BAD0;
                pend = 0;
            end
            if (cyc >= ready_wait) bus_ready = 1'b1;
        end
        check({name, ".done"}, {31'd0, done}, 32'd1);
        check({name, ".stall_cycles"}, stall_cnt, exp_stall);
        check({name, ".beats"}, beats_seen, exp_n);
        we = 1'b0; is_load = 1'b0; bus_ready = 1'b1;
        $display("txn %s addr=%h wd=%h f3=%b stall=%0d beats=%0d rd_data=%h",
                 name, a, d, f3, stall_cnt, beats_seen, rd_data);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; is_load = 1'b0; addr = 32'd0; wd = 32'd0;
        bytectrl = 3'd0; bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.bus_valid", {31'd0, bus_valid}, 32'd0);
        check("reset.stall", {31'd0, stall}, 32'd0);
        check("reset.rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset.rd_data", rd_data, 32'd0);
        check("reset.bus_addr", bus_addr, 32'd0);
        check("reset.wstrb", {28'd0, bus_wstrb}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Aligned word store.
        push_beat(32'h100, 1'b1, 4'b1111, 32'hDEADBEEF);
        access("sw_aligned", 1, 0, 32'h100, 32'hDEADBEEF, 3'b010, 0, 2);

        // Byte store into the top lane.
        push_beat(32'h100, 1'b1, 4'b1000, 32'hAB000000);
        access("sb_lane3", 1, 0, 32'h103, 32'h000000AB, 3'b000, 0, 2);

        // Signed and unsigned half loads from the upper half.
        push_beat(32'h100, 1'b0, 4'b0000, 32'h0);
        rd_words.push_back(32'h80015555);
        exp_rd.push_back(32'hFFFF8001);
        access("lh_sign", 0, 1, 32'h102, 32'h0, 3'b001, 0, 3);

        push_beat(32'h100, 1'b0, 4'b0000, 32'h0);
        rd_words.push_back(32'h80015555);
        exp_rd.push_back(32'h00008001);
        access("lhu_ready_late", 0, 1, 32'h102, 32'h0, 3'b101, 3, 5);

        // Misaligned word load spanning two words.
        push_beat(32'h100, 1'b0, 4'b0000, 32'h0);
        push_beat(32'h104, 1'b0, 4'b0000, 32'h0);
        rd_words.push_back(32'h44332211);
        rd_words.push_back(32'h88776655);
        exp_rd.push_back(32'h55443322);
        access("lw_split", 0, 1, 32'h101, 32'h0, 3'b010, 0, 5);

        // Byte loads, signed and unsigned.
        push_beat(32'h100, 1'b0, 4'b0000, 32'h0);
        rd_words.push_back(32'h00008000);
        exp_rd.push_back(32'hFFFFFF80);
        access("lb_sign", 0, 1, 32'h101, 32'h0, 3'b000, 0, 3);

        push_beat(32'h100, 1'b0, 4'b0000, 32'h0);
        rd_words.push_back(32'h00008000);
        exp_rd.push_back(32'h00000080);
        access("lbu", 0, 1, 32'h101, 32'h0, 3'b100, 0, 3);

        // Half store at the top of the address space: beat 1 wraps to 0.
        push_beat(32'hFFFFFFFC, 1'b1, 4'b1000, 32'h34000000);
        push_beat(32'h00000000, 1'b1, 4'b0001, 32'h00000012);
        access("sh_wrap", 1, 0, 32'hFFFFFFFF, 32'h00001234, 3'b001, 0, 3);

        // Unsigned half load at offset 3 splits.
        push_beat(32'h104, 1'b0, 4'b0000, 32'h0);
        push_beat(32'h108, 1'b0, 4'b0000, 32'h0);
        rd_words.push_back(32'hAA000000);
        rd_words.push_back(32'h000000BB);
        exp_rd.push_back(32'h0000BBAA);
        access("lhu_split", 0, 1, 32'h107, 32'h0, 3'b101, 0, 5);

        // Store and load both requested: the store wins.
        push_beat(32'h200, 1'b1, 4'b1111, 32'h11223344);
        access("st_wins", 1, 1, 32'h200, 32'h11223344, 3'b010, 0, 2);

        // Reset while a request waits in REQ0.
        we = 1'b1; addr = 32'h300; wd = 32'h55; bytectrl = 3'b010; bus_ready = 1'b0;
        @(negedge clk);
        check("rst_mid.idle_stall", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_mid.hold_valid", {31'd0, bus_valid}, 32'd1);
            check("rst_mid.hold_addr", bus_addr, 32'h300);
            check("rst_mid.hold_wdata", bus_wdata, 32'h55);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_mid.bus_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_mid.stall", {31'd0, stall}, 32'd0);
        check("rst_mid.rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_mid.rd_data", rd_data, 32'd0);
        last_load = 32'd0;
        @(posedge clk); #1;
        we = 1'b0; bus_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("txn rst_mid addr=00000300 reset during REQ0");

        push_beat(32'h400, 1'b0, 4'b0000, 32'h0);
        rd_words.push_back(32'h12345678);
        exp_rd.push_back(32'h12345678);
        access("lw_after_rst", 0, 1, 32'h400, 32'h0, 3'b010, 0, 3);

        check("end.beats_left", exp_beats.size(), 0);
        check("end.words_left", rd_words.size(), 0);
        check("end.rd_left", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
